// File: rtl/idex_stage_if.sv
// Signal bundle between the ID/EX pipeline register and its surrounding pipeline.
// IDEX_STALL_COUNT_EN adds the stall_count observation output.
interface idex_stage_if #(
    parameter int WIDTH = 32
);
    logic [WIDTH-1:0] ifid_ir;
    logic             ifid_valid;
    logic [WIDTH-1:0] rf_a;
    logic [WIDTH-1:0] rf_b;
    logic             flush;
    logic [WIDTH-1:0] exmem_ir;
    logic [WIDTH-1:0] exmem_aluout;
    logic [WIDTH-1:0] memwb_ir;
    logic [WIDTH-1:0] memwb_value;
    logic [WIDTH-1:0] idex_ir;
    logic [WIDTH-1:0] idex_a;
    logic [WIDTH-1:0] idex_b;
    logic             idex_valid;
    logic [WIDTH-1:0] ain;
    logic [WIDTH-1:0] bin;
    logic             stall;
`ifdef IDEX_STALL_COUNT_EN
    logic [31:0]      stall_count;
`endif

    modport master (
        output ifid_ir, ifid_valid, rf_a, rf_b, flush,
               exmem_ir, exmem_aluout, memwb_ir, memwb_value,
`ifdef IDEX_STALL_COUNT_EN
        input  stall_count,
`endif
        input  idex_ir, idex_a, idex_b, idex_valid, ain, bin, stall
    );

    modport slave (
        input  ifid_ir, ifid_valid, rf_a, rf_b, flush,
               exmem_ir, exmem_aluout, memwb_ir, memwb_value,
`ifdef IDEX_STALL_COUNT_EN
        output stall_count,
`endif
        output idex_ir, idex_a, idex_b, idex_valid, ain, bin, stall
    );
endinterface

// File: rtl/idex_stage.sv
// ID/EX pipeline register with load-use stall detection and EX operand forwarding.
// Optional IDEX_STALL_COUNT_EN adds a free-running stall cycle counter.
module idex_stage #(
    parameter int               WIDTH  = 32,
    parameter logic [WIDTH-1:0] NOP_IR = 32'h0000_0000
) (
    input logic         clock,
    input logic         reset,
    idex_stage_if.slave bus
);
    localparam logic [5:0] OP_ALU  = 6'd0;
    localparam logic [5:0] OP_JAL  = 6'd3;
    localparam logic [5:0] OP_ADDI = 6'd8;
    localparam logic [5:0] OP_LW   = 6'd35;
    localparam logic [5:0] OP_SW   = 6'd43;

    // Destination register; 0 means the instruction writes nothing.
    function automatic logic [4:0] dest_reg(input logic [5:0] op,
                                            input logic [4:0] rt,
                                            input logic [4:0] rd);
        logic [4:0] d;
        case (op)
            OP_ALU:         d = rd;
            OP_LW, OP_ADDI: d = rt;
            OP_JAL:         d = 5'd31;
            default:        d = 5'd0;
        endcase
        return d;
    endfunction

    function automatic logic uses_rs(input logic [5:0] op);
        return (op == OP_ALU) || (op == OP_LW) || (op == OP_SW) || (op == OP_ADDI);
    endfunction

    function automatic logic uses_rt(input logic [5:0] op);
        return (op == OP_ALU) || (op == OP_SW);
    endfunction

    function automatic logic [WIDTH-1:0] fwd(input logic [4:0]       r,
                                             input logic [WIDTH-1:0] own,
                                             input logic [4:0]       ex_dst,
                                             input logic             ex_lw,
                                             input logic [WIDTH-1:0] ex_val,
                                             input logic [4:0]       wb_dst,
                                             input logic [WIDTH-1:0] wb_val);
        logic [WIDTH-1:0] v;
        if ((r != 5'd0) && (ex_dst == r) && !ex_lw) begin
            v = ex_val;
        end else if ((r != 5'd0) && (wb_dst == r)) begin
            v = wb_val;
        end else begin
            v = own;
        end
        return v;
    endfunction

    logic [WIDTH-1:0] idex_ir_q, idex_ir_d;
    logic [WIDTH-1:0] idex_a_q, idex_a_d;
    logic [WIDTH-1:0] idex_b_q, idex_b_d;
    logic             idex_valid_q, idex_valid_d;
    logic             hazard_s;
    logic [4:0]       ex_dst_s, wb_dst_s;
    logic             unused_s;

    assign unused_s = ^{bus.exmem_ir[10:0], bus.memwb_ir[10:0]};

    // Load-use hazard: the LW in EX targets a register the ID instruction reads.
    always_comb begin
        hazard_s = 1'b0;
        if (idex_valid_q && (idex_ir_q[31:26] == OP_LW) && (idex_ir_q[20:16] != 5'd0)
            && bus.ifid_valid) begin
            hazard_s = (uses_rs(bus.ifid_ir[31:26]) && (idex_ir_q[20:16] == bus.ifid_ir[25:21]))
                    || (uses_rt(bus.ifid_ir[31:26]) && (idex_ir_q[20:16] == bus.ifid_ir[20:16]));
        end else begin
            hazard_s = 1'b0;
        end
    end

    // A flush or a load-use hazard both load a bubble into EX.
    always_comb begin
        idex_ir_d    = bus.ifid_ir;
        idex_a_d     = bus.rf_a;
        idex_b_d     = bus.rf_b;
        idex_valid_d = bus.ifid_valid;
        if (bus.flush || hazard_s) begin
            idex_ir_d    = NOP_IR;
            idex_a_d     = {WIDTH{1'b0}};
            idex_b_d     = {WIDTH{1'b0}};
            idex_valid_d = 1'b0;
        end else begin
            idex_ir_d    = bus.ifid_ir;
            idex_a_d     = bus.rf_a;
            idex_b_d     = bus.rf_b;
            idex_valid_d = bus.ifid_valid;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            idex_ir_q    <= NOP_IR;
            idex_a_q     <= {WIDTH{1'b0}};
            idex_b_q     <= {WIDTH{1'b0}};
            idex_valid_q <= 1'b0;
        end else begin
            idex_ir_q    <= idex_ir_d;
            idex_a_q     <= idex_a_d;
            idex_b_q     <= idex_b_d;
            idex_valid_q <= idex_valid_d;
        end
    end

    assign ex_dst_s = dest_reg(bus.exmem_ir[31:26], bus.exmem_ir[20:16], bus.exmem_ir[15:11]);
    assign wb_dst_s = dest_reg(bus.memwb_ir[31:26], bus.memwb_ir[20:16], bus.memwb_ir[15:11]);

    assign bus.ain = fwd(idex_ir_q[25:21], idex_a_q, ex_dst_s, bus.exmem_ir[31:26] == OP_LW,
                         bus.exmem_aluout, wb_dst_s, bus.memwb_value);
    assign bus.bin = fwd(idex_ir_q[20:16], idex_b_q, ex_dst_s, bus.exmem_ir[31:26] == OP_LW,
                         bus.exmem_aluout, wb_dst_s, bus.memwb_value);

    assign bus.stall      = hazard_s & ~bus.flush;
    assign bus.idex_ir    = idex_ir_q;
    assign bus.idex_a     = idex_a_q;
    assign bus.idex_b     = idex_b_q;
    assign bus.idex_valid = idex_valid_q;

`ifdef IDEX_STALL_COUNT_EN
    logic [31:0] stall_count_q, stall_count_d;

    // Counts stalled cycles; wraps naturally at 32 bits.
    always_comb begin
        stall_count_d = stall_count_q;
        if (bus.stall) begin
            stall_count_d = stall_count_q + 32'd1;
        end else begin
            stall_count_d = stall_count_q;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            stall_count_q <= 32'd0;
        end else begin
            stall_count_q <= stall_count_d;
        end
    end

    assign bus.stall_count = stall_count_q;
`endif
endmodule

// File: tb/tb_idex_stage.sv
// Randomized self-checking bench for idex_stage against a behavioural pipeline model.
module tb_idex_stage;
    logic clock = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   failures = 0;

    idex_stage_if #(.WIDTH(32)) bus();
    idex_stage dut (.clock(clock), .reset(reset), .bus(bus));

    always #5 clock = ~clock;

    // Model of the registered ID/EX contents.
    logic [31:0] m_ir, m_a, m_b, m_cnt;
    logic        m_v;

    function automatic logic [31:0] r_ins(int rd, int rs, int rt);
        return {6'd0, 5'(rs), 5'(rt), 5'(rd), 11'd0};
    endfunction

    function automatic logic [31:0] i_ins(int op, int rs, int rt, int imm);
        return {6'(op), 5'(rs), 5'(rt), 16'(imm)};
    endfunction

    function automatic int dst(logic [31:0] ir);
        int op = int'(ir[31:26]);
        if (op == 0) return int'(ir[15:11]);
        if (op == 35 || op == 8) return int'(ir[20:16]);
        if (op == 3) return 31;
        return 0;
    endfunction

    function automatic bit m_hz();
        int  op  = int'(bus.ifid_ir[31:26]);
        int  ldt = int'(m_ir[20:16]);
        bit  urs = (op == 0) || (op == 35) || (op == 43) || (op == 8);
        bit  urt = (op == 0) || (op == 43);
        if (!(m_v && m_ir[31:26] == 6'd35 && ldt != 0 && bus.ifid_valid)) return 1'b0;
        return (urs && ldt == int'(bus.ifid_ir[25:21])) || (urt && ldt == int'(bus.ifid_ir[20:16]));
    endfunction

    function automatic logic [31:0] m_fwd(int r, logic [31:0] own);
        if (r != 0 && dst(bus.exmem_ir) == r && bus.exmem_ir[31:26] != 6'd35) return bus.exmem_aluout;
        if (r != 0 && dst(bus.memwb_ir) == r) return bus.memwb_value;
        return own;
    endfunction

    task automatic m_reset();
        m_ir = 32'd0; m_a = 32'd0; m_b = 32'd0; m_v = 1'b0; m_cnt = 32'd0;
    endtask

    task automatic drive(logic [31:0] ir, logic v, logic [31:0] a, logic [31:0] b, logic fl,
                         logic [31:0] exir, logic [31:0] exv, logic [31:0] wbir, logic [31:0] wbv);
        @(negedge clock);
        bus.ifid_ir = ir; bus.ifid_valid = v; bus.rf_a = a; bus.rf_b = b; bus.flush = fl;
        bus.exmem_ir = exir; bus.exmem_aluout = exv; bus.memwb_ir = wbir; bus.memwb_value = wbv;
        #1;
    endtask

    // One rising edge with the model following the pipeline-register rules.
    task automatic tick();
        bit hz = m_hz();
        bit fl = bus.flush;
        @(posedge clock);
        if (fl || hz) begin
            m_ir = 32'd0; m_a = 32'd0; m_b = 32'd0; m_v = 1'b0;
        end else begin
            m_ir = bus.ifid_ir; m_a = bus.rf_a; m_b = bus.rf_b; m_v = bus.ifid_valid;
        end
        if (hz && !fl) m_cnt = m_cnt + 32'd1;
        #1;
    endtask

    task automatic test_reset();
        drive(r_ins(3, 1, 2), 1'b1, 32'd5, 32'd7, 1'b0, 32'd0, 32'd0, 32'd0, 32'd0);
        tick();
        checks++;
        if (bus.idex_ir !== r_ins(3, 1, 2)) begin
            failures++; $display("FAIL pre_reset_ir got=%h exp=%h", bus.idex_ir, r_ins(3, 1, 2));
        end
        drive(i_ins(35, 1, 4, 0), 1'b1, 32'd1, 32'd2, 1'b0, 32'd0, 32'd0, 32'd0, 32'd0);
        tick();
        drive(r_ins(5, 4, 6), 1'b1, 32'd3, 32'd4, 1'b0, 32'd0, 32'd0, 32'd0, 32'd0);
        checks++;
        if (bus.stall !== 1'b1) begin
            failures++; $display("FAIL pre_reset_stall got=%b exp=1", bus.stall);
        end
        #2 reset = 1'b1;
        m_reset();
        #1;
        checks++;
        if (bus.idex_ir !== 32'd0 || bus.idex_valid !== 1'b0 || bus.stall !== 1'b0
            || bus.ain !== 32'd0 || bus.bin !== 32'd0) begin
            failures++;
            $display("FAIL async_reset got ir=%h v=%b stall=%b ain=%h bin=%h exp all zero",
                     bus.idex_ir, bus.idex_valid, bus.stall, bus.ain, bus.bin);
        end
`ifdef IDEX_STALL_COUNT_EN
        checks++;
        if (bus.stall_count !== 32'd0) begin
            failures++; $display("FAIL reset_count got=%0d exp=0", bus.stall_count);
        end
`endif
        @(negedge clock);
        reset = 1'b0;
    endtask

    task automatic test_plain_latch();
        drive(r_ins(3, 1, 2), 1'b1, 32'd5, 32'd7, 1'b0, 32'd0, 32'd0, 32'd0, 32'd0);
        tick();
        checks++;
        if (bus.idex_a !== 32'd5 || bus.idex_b !== 32'd7 || bus.ain !== 32'd5 || bus.bin !== 32'd7
            || bus.idex_valid !== 1'b1) begin
            failures++;
            $display("FAIL plain_latch got a=%h b=%h ain=%h bin=%h v=%b exp 5 7 5 7 1",
                     bus.idex_a, bus.idex_b, bus.ain, bus.bin, bus.idex_valid);
        end
    endtask

    task automatic test_load_use();
        drive(i_ins(35, 1, 4, 0), 1'b1, 32'd9, 32'd0, 1'b0, 32'd0, 32'd0, 32'd0, 32'd0);
        tick();
        drive(r_ins(5, 4, 6), 1'b1, 32'd10, 32'd11, 1'b0, 32'd0, 32'd0, 32'd0, 32'd0);
        checks++;
        if (bus.stall !== 1'b1) begin
            failures++; $display("FAIL load_use_stall got=%b exp=1", bus.stall);
        end
        tick();
        checks++;
        if (bus.idex_ir !== 32'd0 || bus.idex_valid !== 1'b0 || bus.stall !== 1'b0) begin
            failures++;
            $display("FAIL load_use_bubble got ir=%h v=%b stall=%b exp 0 0 0",
                     bus.idex_ir, bus.idex_valid, bus.stall);
        end
        tick();
        checks++;
        if (bus.idex_ir !== r_ins(5, 4, 6) || bus.idex_valid !== 1'b1 || bus.stall !== 1'b0) begin
            failures++;
            $display("FAIL load_use_release got ir=%h v=%b stall=%b exp ir=%h 1 0",
                     bus.idex_ir, bus.idex_valid, bus.stall, r_ins(5, 4, 6));
        end
    endtask

    task automatic test_forward_priority();
        drive(r_ins(7, 4, 4), 1'b1, 32'd1, 32'd2, 1'b0, 32'd0, 32'd0, 32'd0, 32'd0);
        tick();
        drive(32'd0, 1'b0, 32'd0, 32'd0, 1'b0, r_ins(4, 1, 2), 32'h11, r_ins(4, 1, 2), 32'h22);
        checks++;
        if (bus.ain !== 32'h11 || bus.bin !== 32'h11) begin
            failures++; $display("FAIL fwd_exmem got ain=%h bin=%h exp 11 11", bus.ain, bus.bin);
        end
        bus.exmem_ir = r_ins(9, 1, 2);
        #1;
        checks++;
        if (bus.ain !== 32'h22 || bus.bin !== 32'h22) begin
            failures++; $display("FAIL fwd_memwb got ain=%h bin=%h exp 22 22", bus.ain, bus.bin);
        end
        bus.exmem_ir = i_ins(35, 1, 4, 0);
        #1;
        checks++;
        if (bus.ain !== 32'h22 || bus.bin !== 32'h22) begin
            failures++; $display("FAIL fwd_no_lw got ain=%h bin=%h exp 22 22", bus.ain, bus.bin);
        end
    endtask

    task automatic test_zero_reg();
        drive(r_ins(3, 0, 0), 1'b1, 32'd0, 32'd0, 1'b0, 32'd0, 32'd0, 32'd0, 32'd0);
        tick();
        drive(32'd0, 1'b0, 32'd0, 32'd0, 1'b0, r_ins(0, 1, 2), 32'hFF, i_ins(8, 1, 0, 3), 32'hEE);
        checks++;
        if (bus.ain !== 32'd0 || bus.bin !== 32'd0) begin
            failures++; $display("FAIL zero_reg got ain=%h bin=%h exp 0 0", bus.ain, bus.bin);
        end
    endtask

    task automatic test_flush_vs_hazard();
        drive(i_ins(35, 1, 4, 0), 1'b1, 32'd9, 32'd0, 1'b0, 32'd0, 32'd0, 32'd0, 32'd0);
        tick();
        drive(r_ins(5, 4, 6), 1'b1, 32'd10, 32'd11, 1'b1, 32'd0, 32'd0, 32'd0, 32'd0);
        checks++;
        if (bus.stall !== 1'b0) begin
            failures++; $display("FAIL flush_stall got=%b exp=0", bus.stall);
        end
        tick();
        checks++;
        if (bus.idex_valid !== 1'b0 || bus.idex_ir !== 32'd0) begin
            failures++; $display("FAIL flush_bubble got v=%b ir=%h exp 0 0", bus.idex_valid, bus.idex_ir);
        end
`ifdef IDEX_STALL_COUNT_EN
        checks++;
        if (bus.stall_count !== m_cnt) begin
            failures++; $display("FAIL flush_count got=%0d exp=%0d", bus.stall_count, m_cnt);
        end
`endif
    endtask

    function automatic logic [31:0] rnd_ins();
        int ops[8] = '{0, 2, 3, 8, 35, 43, 4, 13};
        return {6'(ops[$urandom_range(0, 7)]), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                5'($urandom_range(0, 3)), 11'($urandom)};
    endfunction

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            drive(rnd_ins(), 1'($urandom_range(0, 9) < 8), $urandom, $urandom,
                  1'($urandom_range(0, 9) == 0), rnd_ins(), $urandom, rnd_ins(), $urandom);
            checks++;
            if (bus.stall !== (m_hz() && !bus.flush) || bus.ain !== m_fwd(int'(m_ir[25:21]), m_a)
                || bus.bin !== m_fwd(int'(m_ir[20:16]), m_b)) begin
                failures++;
                $display("FAIL rand_comb[%0d] got stall=%b ain=%h bin=%h exp stall=%b ain=%h bin=%h",
                         i, bus.stall, bus.ain, bus.bin, m_hz() && !bus.flush,
                         m_fwd(int'(m_ir[25:21]), m_a), m_fwd(int'(m_ir[20:16]), m_b));
            end
            tick();
            checks++;
            if (bus.idex_ir !== m_ir || bus.idex_a !== m_a || bus.idex_b !== m_b || bus.idex_valid !== m_v) begin
                failures++;
                $display("FAIL rand_reg[%0d] got ir=%h a=%h b=%h v=%b exp ir=%h a=%h b=%h v=%b",
                         i, bus.idex_ir, bus.idex_a, bus.idex_b, bus.idex_valid, m_ir, m_a, m_b, m_v);
            end
`ifdef IDEX_STALL_COUNT_EN
            checks++;
            if (bus.stall_count !== m_cnt) begin
                failures++; $display("FAIL rand_count[%0d] got=%0d exp=%0d", i, bus.stall_count, m_cnt);
            end
`endif
        end
    endtask

    initial begin
        bus.ifid_ir = 32'd0; bus.ifid_valid = 1'b0; bus.rf_a = 32'd0; bus.rf_b = 32'd0;
        bus.flush = 1'b0; bus.exmem_ir = 32'd0; bus.exmem_aluout = 32'd0;
        bus.memwb_ir = 32'd0; bus.memwb_value = 32'd0;
        m_reset();
        repeat (2) @(negedge clock);
        reset = 1'b0;
        test_reset();
        test_plain_latch();
        test_load_use();
        test_forward_priority();
        test_zero_reg();
        test_flush_vs_hazard();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/idex_stage.md
Name: idex_stage

Overview:
- ID/EX pipeline register for the 5-stage MIPS core.
- Latches the decoded instruction and register-file operands from ID.
- Detects load-use hazards, stalls IF/ID and inserts bubbles.
- Produces the forwarded operand values (Ain, Bin) that the EX-stage operand muxes consume.

Parameters:
- WIDTH, 32: datapath width of operands and IR.
- NOP_IR, 32'h0000_0000: IR value loaded on bubble/flush/reset.

Ports:
- clock  input  1  pipeline clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-high reset.
- ifid_ir  input  WIDTH  instruction in ID.
- ifid_valid  input  1  ID holds a real instruction.
- rf_a  input  WIDTH  register-file read of rs.
- rf_b  input  WIDTH  register-file read of rt.
- flush  input  1  branch/jump redirect; kill ID instruction.
- exmem_ir  input  WIDTH  instruction in EX/MEM.
- exmem_aluout  input  WIDTH  EX/MEM ALU result.
- memwb_ir  input  WIDTH  instruction in MEM/WB.
- memwb_value  input  WIDTH  write-back value (load data or ALU result).
- idex_ir  output  WIDTH  registered IR.
- idex_a  output  WIDTH  registered rs operand.
- idex_b  output  WIDTH  registered rt operand.
- idex_valid  output  1  registered valid.
- ain  output  WIDTH  forwarded rs operand for EX.
- bin  output  WIDTH  forwarded rt operand for EX.
- stall  output  1  hold PC and IF/ID this cycle.

Behaviour:
- Opcodes are IR[31:26]: ALUop=0, Jop=2, JALop=3, ADD_IMM=8, LW=35, SW=43. Fields: rs=[25:21], rt=[20:16], rd=[15:11].
- Destination register of an instruction:
  - ALUop: rd.
  - LW, ADD_IMM: rt.
  - JALop: 31.
  - All others: none.
  - Destination 0 is treated as none.
- Source usage of the ID instruction:
  - rs is used by ALUop, LW, SW, ADD_IMM.
  - rt is used by ALUop, SW.
- Hazard: idex_valid && idex op==LW && idex rt!=0 && (idex rt==ifid rs with rs used, or idex rt==ifid rt with rt used) && ifid_valid.
- stall = hazard && !flush. Combinational from registered state plus ID inputs.
- Register update on each rising clock edge:
  - flush=1: idex_ir<=NOP_IR, idex_a<=0, idex_b<=0, idex_valid<=0.
  - Else if hazard: same bubble values as flush. IF/ID holds by stall, so the load-use stall lasts exactly one cycle.
  - Else: idex_ir<=ifid_ir, idex_a<=rf_a, idex_b<=rf_b, idex_valid<=ifid_valid.
- Reset, asynchronous: idex_ir=NOP_IR, idex_a=0, idex_b=0, idex_valid=0. Hence stall=0, ain=0, bin=0 while reset is held. Reset mid-stall drops the bubble state and stall deasserts immediately.
- Forwarding is combinational, zero latency. Priority for ain, using idex rs:
  1. exmem destination == rs, rs!=0, exmem op!=LW: ain=exmem_aluout.
  2. Else memwb destination == rs, rs!=0: ain=memwb_value.
  3. Else ain=idex_a.
- bin uses the same priority with idex rt.
- EX/MEM destination beats MEM/WB when both match. An LW in EX/MEM is never forwarded; the stall guarantees this case cannot be needed.
- Register 0 is never forwarded; a write to $0 is ignored.

Optional Feature:
- Macro: IDEX_STALL_COUNT_EN.
- Defined:
  - Adds output stall_count [31:0].
  - Increments on every rising edge where stall=1; wraps from 32'hFFFF_FFFF to 0.
  - Cleared by reset.
- Undefined: port and counter are absent; all other behaviour is identical.

Test Plan:
- Reset: assert reset mid-run with a nonzero IR latched -> idex_ir=0, idex_valid=0, stall=0, ain=bin=0 immediately, before any clock edge.
- Plain latch: ifid_ir=ADD $3,$1,$2, rf_a=5, rf_b=7, no hazards -> after 1 edge idex_a=5, idex_b=7, ain=5, bin=7.
- Load-use: idex = LW $4,0($1); ifid = ADD $5,$4,$6 -> stall=1 for exactly one cycle; next idex_ir=0; following edge latches the ADD; stall=0.
- Forward priority: idex = ADD $7,$4,$4; exmem ADD writes $4 with 0x11; memwb writes $4 with 0x22 -> ain=bin=0x11. With exmem changed to write $9 -> ain=bin=0x22.
- Zero register: exmem writes $0 with 0xFF; idex rs=0, idex_a=0 -> ain=0.
- Flush vs hazard: load-use hazard present with flush=1 -> stall=0; next edge bubble (idex_valid=0). With IDEX_STALL_COUNT_EN defined, stall_count is unchanged by this cycle.
